// File: rtl/ps2_kb_event_ctrl.sv
// PS/2 keyboard receiver in the system clock domain: line sync, 11-bit frame FSM,
// E0/F0 prefix folding into make/break events, and a small show-ahead event FIFO.
module ps2_kb_event_ctrl #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int DEPTH          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       frame_err,
  output logic       overflow,
  input  logic       err_clr
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  state_t        state, state_nxt;
  logic [1:0]    ck_sync, dt_sync;
  logic          ck_prev, fall, sd;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          par_ok;
  logic [TW-1:0] to_cnt;
  logic          timeout, byte_ok, err_now;
  logic          ext, brk, push_req;
  evt_t          push_evt, head;
  evt_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, wr_en, drop;

  // Idle-high reset value keeps a released line from looking like a fall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ck_sync <= 2'b11;
      dt_sync <= 2'b11;
      ck_prev <= 1'b1;
    end else begin
      ck_sync <= {ck_sync[0], ps2_clk};
      dt_sync <= {dt_sync[0], ps2_data};
      ck_prev <= ck_sync[1];
    end
  end

  assign fall    = ck_prev & ~ck_sync[1];
  assign sd      = dt_sync[1];
  assign timeout = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) state_nxt = IDLE;
    else if (fall) begin
      case (state)
        IDLE:    if (!sd) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    byte_ok = fall && (state == STOP) && sd && par_ok;
    err_now = timeout
            | (fall && (state == IDLE) && sd)
            | (fall && (state == STOP) && !(sd && par_ok));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      par_ok  <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (fall || state == IDLE) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shreg   <= {sd, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY:  par_ok <= ^{sd, shreg};
          default: ;
        endcase
      end
    end
  end

  // Prefix folding; the event is registered so the FIFO push lands one cycle after the stop fall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      push_req  <= 1'b0;
      push_evt  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_now;
      push_req  <= 1'b0;
      if (err_now) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_ok) begin
        if (shreg == 8'hE0)      ext <= 1'b1;
        else if (shreg == 8'hF0) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (shreg != 8'h00 && shreg != 8'hFF) begin
            push_req <= 1'b1;
            push_evt <= {shreg, ext, brk};
          end
        end
      end
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = evt_valid & evt_ready;
  assign wr_en = push_req & (~full | pop);
  assign drop  = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_evt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
    end
  end

  assign head      = mem[rd_ptr];
  assign evt_valid = (count != '0);
  assign evt_code  = evt_valid ? head.code : 8'h00;
  assign evt_ext   = evt_valid & head.ext;
  assign evt_brk   = evt_valid & head.brk;
endmodule

// File: tb/tb_ps2_kb_event_ctrl.sv
// Bench for ps2_kb_event_ctrl: frame-level reference model with an event queue,
// directed scenarios plus randomized frames and consumer back-pressure.
module tb_ps2_kb_event_ctrl;
  localparam int TO    = 200;
  localparam int DEPTH = 4;

  logic       clk = 0, rst = 0, ps2_clk = 1, ps2_data = 1, evt_ready = 0, err_clr = 0;
  logic [7:0] evt_code;
  logic       evt_ext, evt_brk, evt_valid, frame_err, overflow;

  ps2_kb_event_ctrl #(.TIMEOUT_CYCLES(TO), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_brk(evt_brk), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .frame_err(frame_err), .overflow(overflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: outcome of each whole frame, prefix flags, expected event queue.
  logic [9:0] expq[$];
  bit mext = 0, mbrk = 0, hold = 0, exp_ovf = 0;
  int exp_err = 0;

  function automatic void model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_err++;
      mext = 0; mbrk = 0;
    end else if (b == 8'hE0) mext = 1;
    else if (b == 8'hF0) mbrk = 1;
    else begin
      if (b != 8'h00 && b != 8'hFF) begin
        if (hold && expq.size() >= DEPTH) exp_ovf = 1;
        else expq.push_back({b, mext, mbrk});
      end
      mext = 0; mbrk = 0;
    end
  endfunction

  // Consumer ready driver.
  bit rand_rdy = 0, rdy_val = 1;
  always @(posedge clk) begin
    #1;
    evt_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  // Compare process.
  logic rst_q = 0, fe_q = 0;
  int err_cnt = 0, pops = 0, vld_cyc = 0;
  logic [9:0] last_evt = '0, prev_evt = '0;
  always @(posedge clk) rst_q <= rst;

  always @(negedge clk) begin
    if (!rst_q) begin
      chk("reset_outputs", {evt_code, evt_ext, evt_brk, evt_valid, frame_err, overflow}, 0);
      fe_q = 0;
    end else begin
      if (frame_err) begin
        err_cnt++;
        chk("frame_err_double", fe_q, 0);
      end
      fe_q = frame_err;
      if (evt_valid) begin
        vld_cyc++;
        if (evt_ready) begin
          if (expq.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_event: got %0h required none", {evt_code, evt_ext, evt_brk});
          end else chk("event", {evt_code, evt_ext, evt_brk}, expq.pop_front());
          prev_evt = last_evt;
          last_evt = {evt_code, evt_ext, evt_brk};
          pops++;
        end
      end else chk("empty_head_zero", {evt_code, evt_ext, evt_brk}, 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic v, input int half);
    ps2_data = v;
    cyc(half); ps2_clk = 0;
    cyc(half); ps2_clk = 1;
  endtask

  task automatic send(input logic [7:0] b, input bit pflip = 0, input logic stop = 1,
                      input int half = 8);
    logic par;
    par = ~^b ^ pflip;
    ps2_bit(0, half);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], half);
    ps2_bit(par, half);
    ps2_data = stop;
    cyc(half); ps2_clk = 0;
    model_byte(b, !pflip && stop);
    cyc(half); ps2_clk = 1; ps2_data = 1;
    cyc(half);
  endtask

  int e0, p0, v0;
  task automatic snap();
    e0 = err_cnt; p0 = pops; v0 = vld_cyc;
  endtask

  initial begin
    cyc(4); rst = 1; cyc(4);

    // make code
    snap(); send(8'h1C); cyc(10);
    chk("make_pops", pops - p0, 1);
    chk("make_valid_cycles", vld_cyc - v0, 1);
    chk("make_err", err_cnt - e0, 0);
    chk("make_evt", last_evt, {8'h1C, 2'b00});

    // break code
    snap(); send(8'hF0); send(8'h1C); cyc(10);
    chk("brk_pops", pops - p0, 1);
    chk("brk_evt", last_evt, {8'h1C, 2'b01});

    // extended break then plain make
    snap(); send(8'hE0); send(8'hF0); send(8'h75); send(8'h1C); cyc(10);
    chk("ext_pops", pops - p0, 2);
    chk("ext_evt0", prev_evt, {8'h75, 2'b11});
    chk("ext_evt1", last_evt, {8'h1C, 2'b00});

    // parity errors
    snap(); send(8'h1C, 1); cyc(10);
    chk("par_err", err_cnt - e0, 1);
    chk("par_pops", pops - p0, 0);
    snap(); send(8'hE0); send(8'h33, 1); send(8'h75); cyc(10);
    chk("par_flagclr_err", err_cnt - e0, 1);
    chk("par_flagclr_evt", last_evt, {8'h75, 2'b00});

    // stray fall with data high while idle
    snap(); ps2_bit(1, 8); model_byte(8'h00, 0); cyc(10);
    chk("idle_start_err", err_cnt - e0, 1);

    // stop bit low, then keyboard error code 00
    snap(); send(8'h2A, 0, 0); send(8'hF0); send(8'h00); send(8'h4B); cyc(10);
    chk("stop_err", err_cnt - e0, 1);
    chk("errcode_evt", last_evt, {8'h4B, 2'b00});

    // timeout after 4 data bits
    snap(); send(8'hE0);
    ps2_bit(0, 8);
    for (int i = 0; i < 4; i++) ps2_bit(1, 8);
    cyc(TO + 20); model_byte(8'h00, 0);
    chk("timeout_err", err_cnt - e0, 1);
    send(8'h29); cyc(10);
    chk("timeout_next_evt", last_evt, {8'h29, 2'b00});

    // overflow
    rdy_val = 0; hold = 1; cyc(2);
    snap();
    for (int i = 0; i < 5; i++) send(8'h11 + 8'(i));
    cyc(10);
    chk("ovf_set", overflow, 1);
    chk("ovf_valid", evt_valid, 1);
    chk("ovf_head", evt_code, 8'h11);
    hold = 0; rdy_val = 1; cyc(20);
    chk("ovf_drain_pops", pops - p0, 4);
    chk("ovf_last", last_evt, {8'h14, 2'b00});
    chk("ovf_sticky", overflow, exp_ovf);
    err_clr = 1; cyc(1); err_clr = 0; exp_ovf = 0; cyc(1);
    chk("ovf_cleared", overflow, exp_ovf);

    // reset mid-frame with an event held
    rdy_val = 0; hold = 1; cyc(2);
    send(8'h42); cyc(10);
    chk("rst_held_valid", evt_valid, 1);
    ps2_bit(0, 8); ps2_bit(1, 8); ps2_bit(0, 8);
    rst = 0; expq.delete(); mext = 0; mbrk = 0; exp_ovf = 0;
    cyc(3); rst = 1; hold = 0; rdy_val = 1; cyc(4);
    snap(); send(8'h5A); cyc(10);
    chk("rst_next_evt", last_evt, {8'h5A, 2'b00});
    chk("rst_next_pops", pops - p0, 1);

    // randomized frames with random back-pressure
    rand_rdy = 1;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send(b, $urandom_range(0, 9) == 0, $urandom_range(0, 15) != 0, $urandom_range(6, 20));
      cyc($urandom_range(0, 30));
    end
    rand_rdy = 0; rdy_val = 1; cyc(50);

    chk("err_total", err_cnt, exp_err);
    chk("queue_empty", expq.size(), 0);
    chk("ovf_final", overflow, exp_ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ps2_kb_event_ctrl.md
Name: ps2_kb_event_ctrl

Overview:
System-clock-domain PS/2 keyboard controller. It synchronises the raw PS/2 clock and data lines and sequences 11-bit frame reception, including start, parity and stop checks and an inter-bit timeout. It decodes the E0/F0 prefix sequences into single make/break events and buffers those events in a small FIFO with a valid/ready output handshake. It replaces direct use of the keyboard clock as a flop clock and feeds the key-handling logic downstream.

Parameters:
TIMEOUT_CYCLES, 5000, clk cycles allowed between PS/2 falling edges inside a frame (100 us at 50 MHz); minimum 16
DEPTH, 4, event FIFO depth in entries; power of 2, at least 2

Ports:
clk  in  1  system clock; all flops on posedge
rst  in  1  synchronous, active-low reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
evt_code  out  8  scan code of the head event
evt_ext  out  1  head event was E0-prefixed
evt_brk  out  1  head event is a break (F0-prefixed)
evt_valid  out  1  FIFO not empty
evt_ready  in  1  consumer accepts the head event when evt_valid=1 and evt_ready=1
frame_err  out  1  one-cycle pulse on start, parity, stop or timeout error
overflow  out  1  sticky; set when an event is dropped because the FIFO is full
err_clr  in  1  clears overflow; takes effect the next cycle

Behaviour:
- Reset (rst=0 at posedge clk): all outputs are 0 (evt_code=8'h00, evt_ext=0, evt_brk=0, evt_valid=0, frame_err=0, overflow=0). The FSM goes to IDLE, the FIFO is emptied, the prefix flags are cleared and the synchroniser flops are set to 1. Reset mid-frame discards the partial frame.
- Synchronisation: two-flop synchroniser on each of ps2_clk and ps2_data.
  - A "fall" is the cycle where the synced clock value is 0 and its previous value was 1.
  - Data is sampled from synced ps2_data on the fall cycle only.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a fall with data=0, go to DATA with bit count 0. On a fall with data=1, pulse frame_err and stay in IDLE.
  - DATA: on each fall, shift the bit in LSB first. After the 8th bit go to PARITY.
  - PARITY: on a fall, check odd parity (the 8 data bits plus the parity bit must have odd weight). Record the result and go to STOP.
  - STOP: on a fall, return to IDLE. If data=1 and parity was good, the byte is delivered to the decoder on this fall cycle N. Otherwise pulse frame_err on cycle N+1 and deliver nothing.
- Timeout:
  - The counter clears on every fall and increments each cycle while the FSM is not in IDLE.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE and frame_err pulses on the next cycle.
  - The counter is held at 0 in IDLE.
- Prefix decoder (registered flags ext and brk):
  - Byte E0: set ext, no event.
  - Byte F0: set brk, no event.
  - Byte 00 or FF: keyboard error code; clear both flags, no event, no frame_err.
  - Any other byte: push {byte, ext, brk} on cycle N+1, then clear both flags.
  - Any frame_err also clears both flags.
- Event FIFO:
  - Show-ahead: a push on cycle N+1 makes evt_valid=1 from cycle N+2 when the FIFO was empty.
  - evt_code, evt_ext and evt_brk always reflect the head entry, and are 0 when the FIFO is empty.
  - Pop occurs when evt_valid=1 and evt_ready=1.
  - Push while full with no pop in the same cycle: the event is dropped and overflow is set.
  - Push and pop in the same cycle while full: both succeed and overflow is unchanged.
  - Push and pop in the same cycle while empty: the push is stored and evt_valid rises the next cycle.
  - Pointers are log2(DEPTH) bits and wrap naturally. A separate count register of log2(DEPTH)+1 bits distinguishes full from empty.
- overflow: if err_clr and a new drop occur in the same cycle, overflow stays 1.
- frame_err is never asserted for two consecutive cycles from a single event.

Test Plan:
- Make code: frame 0x1C sent (parity bit 0, stop 1) with evt_ready=1 -> exactly one event {code 1C, ext 0, brk 0}; evt_valid high for exactly one cycle; frame_err stays 0.
- Break code: frames F0, 1C sent -> exactly one event {code 1C, ext 0, brk 1}; no event for F0.
- Extended break: frames E0, F0, 75 sent, then 1C -> two events: {75, ext 1, brk 1} then {1C, 0, 0}, confirming the flags were cleared.
- Parity error: 0x1C sent with parity bit 1 -> one frame_err pulse, no event. Then E0, a bad-parity frame, then 75 -> event {75, ext 0, brk 0}.
- Timeout: ps2_clk stalled after 4 data bits for TIMEOUT_CYCLES cycles -> frame_err pulse and FSM in IDLE. The next good frame 0x29 yields event {29, 0, 0}.
- Overflow and reset: evt_ready=0 and 5 make codes 11, 12, 13, 14, 15 sent -> overflow=1 and FIFO holds 11 to 14. With evt_ready=1 they drain in order and 15 is absent. An err_clr pulse then clears overflow. Reset asserted mid-frame -> all outputs 0, and the next frame decodes correctly.
